// File: rtl/eeprom_loader.sv
// Packs an incoming byte stream into 32-bit words, writes them into the eeprom
// via str/a/d_in, then streams the stored words back out on a valid/ready port.
module eeprom_loader #(
    parameter int unsigned NW = 16,
    parameter int unsigned AW = 4
) (
    input  logic          c,
    input  logic          rst,
    input  logic [7:0]    b_in,
    input  logic          b_vld,
    output logic          b_rdy,
    input  logic          go,
    input  logic          clr,
    output logic          str,
    output logic          ld,
    output logic [AW-1:0] a,
    output logic [31:0]   d_in,
    input  logic [31:0]   d,
    output logic [31:0]   w_out,
    output logic          w_vld,
    input  logic          w_rdy,
    output logic          full
);

    typedef enum logic [2:0] {
        StFill,
        StWr,
        StWgap,
        StFull,
        StRreq,
        StRcap,
        StRout
    } state_e;

    localparam logic [AW-1:0] LastAddr = AW'(NW - 1);

    state_e        state_q, state_d;
    logic [1:0]    bc_q;
    logic [AW-1:0] wp_q;
    logic [AW-1:0] rp_q;
    logic [31:0]   d_in_q;
    logic [31:0]   w_out_q;
    logic          byte_acc;

    assign byte_acc = b_vld & b_rdy;

    // State register
    always_ff @(posedge c) begin
        if (rst) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clr overrides every transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill: if (byte_acc && bc_q == 2'd3) state_d = StWr;
            StWr:   state_d = StWgap;
            StWgap: state_d = (wp_q == LastAddr) ? StFull : StFill;
            StFull: if (go) state_d = StRreq;
            StRreq: state_d = StRcap;
            StRcap: state_d = StRout;
            StRout: begin
                if (w_rdy) state_d = (rp_q == LastAddr) ? StFull : StRreq;
            end
            default: state_d = StFill;
        endcase
        if (clr) state_d = StFill;
    end

    // Outputs decoded from the current state
    always_comb begin
        b_rdy = 1'b0;
        str   = 1'b0;
        ld    = 1'b0;
        w_vld = 1'b0;
        full  = 1'b0;
        a     = wp_q;
        unique case (state_q)
            StFill: b_rdy = ~rst;
            StWr:   str = 1'b1;
            StWgap: ;
            StFull: full = 1'b1;
            StRreq: begin
                ld = 1'b1;
                a  = rp_q;
            end
            StRcap: a = rp_q;
            StRout: begin
                w_vld = 1'b1;
                a     = rp_q;
            end
            default: ;
        endcase
    end

    assign d_in  = d_in_q;
    assign w_out = w_out_q;

    // Datapath: byte packing, pointers and read capture
    always_ff @(posedge c) begin
        if (rst) begin
            bc_q    <= 2'd0;
            wp_q    <= '0;
            rp_q    <= '0;
            d_in_q  <= 32'd0;
            w_out_q <= 32'd0;
        end else if (clr) begin
            bc_q   <= 2'd0;
            wp_q   <= '0;
            rp_q   <= '0;
            d_in_q <= 32'd0;
        end else begin
            if (byte_acc) begin
                d_in_q[{bc_q, 3'b000} +: 8] <= b_in;
                bc_q                        <= bc_q + 2'd1;
            end
            // Pointers saturate at the last word so a never leaves 0..NW-1
            if (state_q == StWgap && wp_q != LastAddr) begin
                wp_q <= wp_q + 1'b1;
            end
            if (state_q == StFull && go) begin
                rp_q <= '0;
            end
            if (state_q == StRcap) begin
                w_out_q <= d;
            end
            if (state_q == StRout && w_rdy && rp_q != LastAddr) begin
                rp_q <= rp_q + 1'b1;
            end
        end
    end

    a_no_str_ld: assert property (@(posedge c) !(str && ld));

endmodule

// File: tb/tb_eeprom_loader.sv
// Self-checking bench for eeprom_loader: behavioural eeprom, word-level reference
// memory, and per-scenario tasks with inline comparisons.
module tb_eeprom_loader;

    localparam int NW = 16;
    localparam int AW = 4;

    logic          c = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    b_in = 8'd0;
    logic          b_vld = 1'b0;
    logic          b_rdy;
    logic          go = 1'b0;
    logic          clr = 1'b0;
    logic          str;
    logic          ld;
    logic [AW-1:0] a;
    logic [31:0]   d_in;
    logic [31:0]   d = 32'd0;
    logic [31:0]   w_out;
    logic          w_vld;
    logic          w_rdy = 1'b0;
    logic          full;

    always #5 c = ~c;

    eeprom_loader #(.NW(NW), .AW(AW)) dut (
        .c(c), .rst(rst), .b_in(b_in), .b_vld(b_vld), .b_rdy(b_rdy), .go(go), .clr(clr),
        .str(str), .ld(ld), .a(a), .d_in(d_in), .d(d), .w_out(w_out), .w_vld(w_vld),
        .w_rdy(w_rdy), .full(full)
    );

    // Eeprom: registered read, write on str
    logic [31:0] mem [NW];
    always @(posedge c) begin
        if (str) mem[a] <= d_in;
        if (ld) d <= mem[a];
    end

    // Reference contents: word i as the bench sent it
    logic [31:0] exp_mem [NW];

    int checks = 0;
    int errors = 0;

    // Observation logs, sampled on the falling edge
    int          cyc = 0;
    int          wr_a[$];
    logic [31:0] wr_d[$];
    int          wr_cyc[$];
    logic [31:0] rd_w[$];
    int          rd_cyc[$];
    int          ld_a[$];
    int          go_cyc = -1;
    int          full_cyc = -1;
    int          both_cnt = 0;
    int          dbl_str = 0;
    int          unstable = 0;
    logic        prev_str = 1'b0;
    logic        prev_full = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_w = 32'd0;

    always @(negedge c) begin
        cyc++;
        if (str) begin
            wr_a.push_back(int'(a));
            wr_d.push_back(d_in);
            wr_cyc.push_back(cyc);
        end
        if (ld) ld_a.push_back(int'(a));
        if (w_vld && w_rdy) begin
            rd_w.push_back(w_out);
            rd_cyc.push_back(cyc);
        end
        if (str && ld) both_cnt++;
        if (str && prev_str) dbl_str++;
        if (full && !prev_full) full_cyc = cyc;
        if (go && full) go_cyc = cyc;
        if (prev_stall && (!w_vld || w_out !== prev_w)) unstable++;
        prev_str   = str;
        prev_full  = full;
        prev_stall = w_vld && !w_rdy;
        prev_w     = w_out;
    end

    task automatic clear_logs();
        wr_a.delete(); wr_d.delete(); wr_cyc.delete();
        rd_w.delete(); rd_cyc.delete(); ld_a.delete();
        go_cyc = -1;
        full_cyc = -1;
    endtask

    task automatic step();
        @(posedge c);
        #1;
    endtask

    // Presents one byte and returns one cycle after its transfer; b_vld stays high
    task automatic send_byte(input logic [7:0] v);
        int n = 0;
        b_in  = v;
        b_vld = 1'b1;
        while (!b_rdy && n < 100) begin
            step();
            n++;
        end
        if (!b_rdy) begin
            checks++;
            errors++;
            $display("FAIL send_byte timeout: b_rdy=%0b required 1", b_rdy);
        end
        step();
    endtask

    task automatic fill_word(input logic [31:0] w, input int gap_max);
        for (int k = 0; k < 4; k++) begin
            if (gap_max > 0) begin
                b_vld = 1'b0;
                repeat ($urandom_range(0, gap_max)) step();
            end
            send_byte(w[8*k +: 8]);
        end
    endtask

    task automatic wait_full(input string tag);
        int n = 0;
        while (!full && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (!full) begin
            errors++;
            $display("FAIL %s wait_full: full=%0b required 1", tag, full);
        end
        step();
    endtask

    task automatic wait_reads(input int cnt, input string tag);
        int n = 0;
        while (!(rd_w.size() == cnt && full) && n < 600) begin
            step();
            n++;
        end
        checks++;
        if (rd_w.size() != cnt) begin
            errors++;
            $display("FAIL %s read_count: got %0d required %0d", tag, rd_w.size(), cnt);
        end
    endtask

    task automatic check_reads(input string tag);
        for (int i = 0; i < NW && i < rd_w.size(); i++) begin
            checks++;
            if (rd_w[i] !== exp_mem[i]) begin
                errors++;
                $display("FAIL %s word[%0d]: got %h required %h", tag, i, rd_w[i], exp_mem[i]);
            end
        end
    endtask

    task automatic test_reset();
        step();
        checks += 8;
        if (b_rdy !== 1'b0) begin errors++; $display("FAIL rst b_rdy: got %b required 0", b_rdy); end
        if (str !== 1'b0) begin errors++; $display("FAIL rst str: got %b required 0", str); end
        if (ld !== 1'b0) begin errors++; $display("FAIL rst ld: got %b required 0", ld); end
        if (a !== 4'd0) begin errors++; $display("FAIL rst a: got %0d required 0", a); end
        if (d_in !== 32'd0) begin errors++; $display("FAIL rst d_in: got %h required 0", d_in); end
        if (w_out !== 32'd0) begin errors++; $display("FAIL rst w_out: got %h required 0", w_out); end
        if (w_vld !== 1'b0) begin errors++; $display("FAIL rst w_vld: got %b required 0", w_vld); end
        if (full !== 1'b0) begin errors++; $display("FAIL rst full: got %b required 0", full); end
        rst = 1'b0;
        #1;
        checks++;
        if (b_rdy !== 1'b1) begin errors++; $display("FAIL rst_release b_rdy: got %b required 1", b_rdy); end
    endtask

    task automatic test_fill();
        clear_logs();
        for (int i = 0; i < NW; i++) begin
            exp_mem[i] = 32'(i + 1);
            fill_word(32'(i + 1), 0);
        end
        b_vld = 1'b0;
        wait_full("fill");
        checks++;
        if (wr_a.size() != NW) begin
            errors++;
            $display("FAIL fill str_count: got %0d required %0d", wr_a.size(), NW);
        end
        for (int i = 0; i < NW && i < wr_a.size(); i++) begin
            checks += 2;
            if (wr_a[i] != i) begin
                errors++; $display("FAIL fill addr[%0d]: got %0d required %0d", i, wr_a[i], i);
            end
            if (wr_d[i] !== exp_mem[i]) begin
                errors++; $display("FAIL fill data[%0d]: got %h required %h", i, wr_d[i], exp_mem[i]);
            end
            if (i > 0) begin
                checks++;
                if (wr_cyc[i] - wr_cyc[i-1] != 6) begin
                    errors++;
                    $display("FAIL fill spacing[%0d]: got %0d required 6", i, wr_cyc[i] - wr_cyc[i-1]);
                end
            end
        end
        checks += 2;
        if (wr_cyc.size() == NW && full_cyc != wr_cyc[NW-1] + 2) begin
            errors++;
            $display("FAIL fill full_time: got %0d required %0d", full_cyc, wr_cyc[NW-1] + 2);
        end
        if (dbl_str != 0) begin errors++; $display("FAIL fill str_width: got %0d required 0", dbl_str); end
    endtask

    task automatic test_read_fast();
        clear_logs();
        w_rdy = 1'b1;
        go = 1'b1;
        step();
        go = 1'b0;
        wait_reads(NW, "read_fast");
        check_reads("read_fast");
        checks += 2;
        if (ld_a.size() != NW) begin
            errors++; $display("FAIL read_fast ld_count: got %0d required %0d", ld_a.size(), NW);
        end
        if (rd_cyc.size() > 0 && rd_cyc[0] != go_cyc + 3) begin
            errors++; $display("FAIL read_fast latency: got %0d required %0d", rd_cyc[0] - go_cyc, 3);
        end
        for (int i = 0; i < ld_a.size() && i < NW; i++) begin
            checks++;
            if (ld_a[i] != i) begin errors++; $display("FAIL read_fast ld_a[%0d]: got %0d required %0d", i, ld_a[i], i); end
        end
        for (int i = 1; i < rd_cyc.size(); i++) begin
            checks++;
            if (rd_cyc[i] - rd_cyc[i-1] != 3) begin
                errors++; $display("FAIL read_fast rate[%0d]: got %0d required 3", i, rd_cyc[i] - rd_cyc[i-1]);
            end
        end
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL read_fast full_after: got %b required 1", full); end
        w_rdy = 1'b0;
    endtask

    task automatic test_read_stall();
        int k = 0;
        clear_logs();
        go = 1'b1;
        step();
        go = 1'b0;
        while (!(rd_w.size() == NW && full) && k < 600) begin
            w_rdy = (k % 4 == 0);
            step();
            k++;
        end
        w_rdy = 1'b0;
        checks += 3;
        if (rd_w.size() != NW) begin errors++; $display("FAIL stall count: got %0d required %0d", rd_w.size(), NW); end
        if (ld_a.size() != NW) begin errors++; $display("FAIL stall ld_count: got %0d required %0d", ld_a.size(), NW); end
        if (unstable != 0) begin errors++; $display("FAIL stall w_out_stable: got %0d changes required 0", unstable); end
        check_reads("stall");
    endtask

    task automatic test_rst_mid_write();
        logic [31:0] w;
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks += 2;
        if (full !== 1'b0) begin errors++; $display("FAIL clr_full full: got %b required 0", full); end
        if (b_rdy !== 1'b1) begin errors++; $display("FAIL clr_full b_rdy: got %b required 1", b_rdy); end
        for (int i = 0; i < 6; i++) begin
            w = $urandom;
            if (i < 5) exp_mem[i] = w;
            fill_word(w, 0);
        end
        b_vld = 1'b0;
        checks++;
        if (!(str === 1'b1 && a === 4'd5)) begin
            errors++; $display("FAIL rst_wr in_wr: got str=%b a=%0d required str=1 a=5", str, a);
        end
        rst = 1'b1;
        step();
        checks += 3;
        if (str !== 1'b0) begin errors++; $display("FAIL rst_wr str: got %b required 0", str); end
        if (a !== 4'd0) begin errors++; $display("FAIL rst_wr a: got %0d required 0", a); end
        if (b_rdy !== 1'b0) begin errors++; $display("FAIL rst_wr b_rdy: got %b required 0", b_rdy); end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (b_rdy !== 1'b1) begin errors++; $display("FAIL rst_wr b_rdy_after: got %b required 1", b_rdy); end
        clear_logs();
        w = $urandom;
        exp_mem[0] = w;
        fill_word(w, 0);
        b_vld = 1'b0;
        repeat (3) step();
        checks++;
        if (wr_a.size() != 1 || wr_a[0] != 0 || wr_d[0] !== w) begin
            errors++;
            $display("FAIL rst_wr rewrite: got n=%0d a=%0d d=%h required n=1 a=0 d=%h",
                     wr_a.size(), (wr_a.size() > 0) ? wr_a[0] : -1,
                     (wr_d.size() > 0) ? wr_d[0] : 32'hx, w);
        end
    endtask

    task automatic test_go_in_fill();
        logic [31:0] w;
        go = 1'b1;
        step();
        go = 1'b0;
        checks += 3;
        if (ld !== 1'b0) begin errors++; $display("FAIL go_fill ld: got %b required 0", ld); end
        if (full !== 1'b0) begin errors++; $display("FAIL go_fill full: got %b required 0", full); end
        if (b_rdy !== 1'b1) begin errors++; $display("FAIL go_fill b_rdy: got %b required 1", b_rdy); end
        repeat (4) step();
        checks++;
        if (ld_a.size() != 0) begin errors++; $display("FAIL go_fill queued: got %0d loads required 0", ld_a.size()); end
        for (int i = 1; i < NW; i++) begin
            w = $urandom;
            exp_mem[i] = w;
            fill_word(w, 2);
        end
        b_vld = 1'b0;
        wait_full("go_fill");
        checks++;
        if (wr_a.size() != NW) begin errors++; $display("FAIL go_fill str_count: got %0d required %0d", wr_a.size(), NW); end
        for (int i = 0; i < NW && i < wr_a.size(); i++) begin
            checks++;
            if (wr_a[i] != i || wr_d[i] !== exp_mem[i]) begin
                errors++;
                $display("FAIL go_fill write[%0d]: got a=%0d d=%h required a=%0d d=%h", i, wr_a[i], wr_d[i], i, exp_mem[i]);
            end
        end
    endtask

    task automatic test_clr_during_read();
        int n = 0;
        clear_logs();
        w_rdy = 1'b1;
        go = 1'b1;
        step();
        go = 1'b0;
        while (!(ld && a == 4'd7) && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (!(ld && a == 4'd7)) begin errors++; $display("FAIL clr_rd reach_word7: got ld=%b a=%0d required ld=1 a=7", ld, a); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks += 5;
        if (w_vld !== 1'b0) begin errors++; $display("FAIL clr_rd w_vld: got %b required 0", w_vld); end
        if (full !== 1'b0) begin errors++; $display("FAIL clr_rd full: got %b required 0", full); end
        if (b_rdy !== 1'b1) begin errors++; $display("FAIL clr_rd b_rdy: got %b required 1", b_rdy); end
        if (ld !== 1'b0 || str !== 1'b0) begin errors++; $display("FAIL clr_rd strobes: got ld=%b str=%b required 0 0", ld, str); end
        if (a !== 4'd0) begin errors++; $display("FAIL clr_rd a: got %0d required 0", a); end
        repeat (4) step();
        w_rdy = 1'b0;
        checks += 2;
        if (rd_w.size() != 7) begin errors++; $display("FAIL clr_rd words: got %0d required 7", rd_w.size()); end
        if (ld_a.size() != 8) begin errors++; $display("FAIL clr_rd loads: got %0d required 8", ld_a.size()); end
        check_reads("clr_rd");
    endtask

    task automatic test_deadbeef();
        clear_logs();
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        b_vld = 1'b0;
        repeat (3) step();
        checks++;
        if (wr_d.size() != 1 || wr_d[0] !== 32'hDEADBEEF || wr_a[0] != 0) begin
            errors++;
            $display("FAIL deadbeef d_in: got %h required deadbeef at a=0",
                     (wr_d.size() > 0) ? wr_d[0] : 32'hx);
        end
    endtask

    task automatic test_random();
        int k = 0;
        logic [31:0] w;
        clr = 1'b1;
        step();
        clr = 1'b0;
        clear_logs();
        for (int i = 0; i < NW; i++) begin
            w = $urandom;
            exp_mem[i] = w;
            fill_word(w, 3);
        end
        b_vld = 1'b0;
        wait_full("random");
        clear_logs();
        go = 1'b1;
        step();
        go = 1'b0;
        while (!(rd_w.size() == NW && full) && k < 800) begin
            w_rdy = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        w_rdy = 1'b0;
        checks += 4;
        if (rd_w.size() != NW) begin errors++; $display("FAIL random count: got %0d required %0d", rd_w.size(), NW); end
        if (unstable != 0) begin errors++; $display("FAIL random w_out_stable: got %0d required 0", unstable); end
        if (both_cnt != 0) begin errors++; $display("FAIL random str_ld_overlap: got %0d required 0", both_cnt); end
        if (dbl_str != 0) begin errors++; $display("FAIL random str_width: got %0d required 0", dbl_str); end
        check_reads("random");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_read_fast();
        test_read_stall();
        test_rst_mid_write();
        test_go_in_fill();
        test_clr_during_read();
        test_deadbeef();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/eeprom_loader.md
Name: eeprom_loader

Overview:
- Front-end stage that fills the 16x32 eeprom program/parameter store and later streams its contents to the display pipeline.
- Accepts a byte stream with a valid/ready handshake, packs each 4 bytes into a 32-bit word, and writes it into the eeprom using the eeprom's str/a/d_in write protocol.
- On command, reads every location back in address order via ld/a/d and presents the words downstream with a valid/ready handshake.

Parameters:
- NW, 16, number of eeprom words filled and read back; legal range 1..2^AW.
- AW, 4, eeprom address width.

Ports:
- c, in, 1, clock; all state changes on the rising edge.
- rst, in, 1, synchronous active-high reset.
- b_in, in, 8, incoming byte.
- b_vld, in, 1, b_in valid.
- b_rdy, out, 1, loader accepts a byte; a transfer occurs when b_vld and b_rdy are both high at a rising edge.
- go, in, 1, start read-back; sampled only in state FULL.
- clr, in, 1, abandon current contents and return to FILL.
- str, out, 1, eeprom store strobe.
- ld, out, 1, eeprom load strobe.
- a, out, AW, eeprom address.
- d_in, out, 32, eeprom write data.
- d, in, 32, eeprom read data; registered, valid the cycle after the edge that samples ld=1.
- w_out, out, 32, word to downstream.
- w_vld, out, 1, w_out valid.
- w_rdy, in, 1, downstream accepts; a transfer occurs when w_vld and w_rdy are both high at a rising edge.
- full, out, 1, high in FULL: all NW words are written and the loader is idle.

Behaviour:
- Reset (synchronous, active-high): state FILL; byte count, write pointer and read pointer = 0.
  - Outputs: str=0, ld=0, a=0, d_in=0, w_out=0, w_vld=0, full=0, b_rdy=0 during the reset cycle.
  - str and ld go low in the same edge that samples rst, so an eeprom access in flight is cut off.
- FILL (b_rdy=1):
  - Each accepted byte is placed little-endian: byte 0 → d_in[7:0], byte 3 → d_in[31:24].
  - Accepting the 4th byte moves to WR.
- WR: str=1 for exactly one cycle; a = write pointer, d_in held stable; b_rdy=0.
- WGAP: str=0 for one cycle; a and d_in unchanged; b_rdy=0; write pointer increments.
  - If the completed write was word NW-1, go to FULL.
  - Otherwise return to FILL with byte count = 0.
- FULL: full=1, b_rdy=0. go=1 moves to RREQ with read pointer = 0.
- RREQ: ld=1, a = read pointer, for one cycle.
- RCAP: ld=0; capture d into w_out at the end of the cycle.
- ROUT: w_vld=1; w_out held until the handshake.
  - On handshake: if read pointer = NW-1, go to FULL; otherwise increment and go to RREQ.
  - w_vld deasserts in the cycle after the handshake.
- Throughput:
  - Write: one word per 2 cycles after its 4th byte.
  - Read: 3 cycles per word with w_rdy held high. First w_vld is 3 cycles after the edge that samples go.
- Boundaries and priorities:
  - Priority: rst > clr > go.
  - clr in any state: next state FILL, all pointers = 0, str=ld=w_vld=full=0 from the next cycle. A partially assembled word is discarded; eeprom contents are not erased.
  - go outside FULL is ignored, not queued.
  - b_vld outside FILL is not accepted; b_rdy=0 there.
  - str and ld are never high in the same cycle.
  - a never exceeds NW-1; pointers do not wrap within one fill or read pass.
  - w_rdy held low indefinitely stalls in ROUT with w_out stable.

Test Plan:
1. Reset, then send bytes 0x01,0x00,0x00,0x00, 0x02,0x00,0x00,0x00, … (word i = i+1, 64 bytes, b_vld always high).
   - Required: 16 one-cycle str pulses, each followed by one str=0 cycle.
   - Required: a = 0..15, d_in = 0x1..0x10 during each pulse.
   - Required: full=1 after the last WGAP.
2. From FULL, pulse go with w_rdy=1.
   - Required: w_out = 0x1..0x10 in order; ld pulses with a = 0..15.
   - Required: first w_vld 3 cycles after go; returns to full=1.
3. Read back with w_rdy toggling 1 cycle on, 3 off.
   - Required: w_out stable while w_vld=1 and w_rdy=0.
   - Required: no word skipped or duplicated; 16 transfers total.
4. Assert rst in the WR cycle of word 5.
   - Required: str=0 next cycle, a=0, b_rdy=0 during reset then 1.
   - Required: the next 4 bytes are written to address 0.
5. Pulse go during FILL, then clr during the read of word 7.
   - Required: go has no effect.
   - Required: after clr, w_vld=0 next cycle, state FILL, full=0, b_rdy=1.
6. Bytes 0xEF,0xBE,0xAD,0xDE.
   - Required: d_in = 0xDEADBEEF at the str pulse.
